// File: rtl/data_memory_manager_generic.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_manager_generic
//  Description : Byte-addressed 32-bit data memory with word, halfword and
//                byte access. Writes are merged into the addressed lanes.
//                Reads are combinational and zero-extend narrow accesses.
//                An asynchronous active-low reset clears every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_manager_generic #(
   parameter int ADDR_W = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] address_i,
   input  logic [31:0] data_i,
   input  logic        wren_i,
   input  logic [31:0] byte_mode_i,
   output logic [31:0] data_o
);

   localparam int c_DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] c_MODE_BYTE = 2'b01;
   localparam logic [1:0] c_MODE_HALF = 2'b10;

   // The data array itself carries no reset. A per-word valid bit is cleared
   // asynchronously instead; a word whose valid bit is low reads as zero and
   // partial writes into it merge against zero, which is indistinguishable
   // from clearing the whole array.
   logic [31:0]        r_mem [c_DEPTH];
   logic [c_DEPTH-1:0] r_valid;

   logic [ADDR_W-1:0]  w_idx;
   logic [1:0]         w_byte_lane;
   logic               w_half_lane;
   logic [1:0]         w_mode;
   logic [31:0]        w_cur;
   logic [31:0]        w_new;
   logic [7:0]         w_rd_byte;
   logic [15:0]        w_rd_half;
   logic               w_unused;

   assign w_idx       = address_i[ADDR_W+1:2];
   assign w_byte_lane = address_i[1:0];
   assign w_half_lane = address_i[1];
   assign w_mode      = byte_mode_i[1:0];

   // Upper address bits wrap away and upper mode bits are don't-care.
   assign w_unused = ^{address_i[31:ADDR_W+2], byte_mode_i[31:2]};

   // Current contents of the addressed word (zero until first written).
   assign w_cur = r_valid[w_idx] ? r_mem[w_idx] : 32'h0000_0000;

   // Merge write data into the addressed lane(s) of the current word.
   always_comb begin
      w_new = w_cur;
      case (w_mode)
         c_MODE_BYTE: w_new[{w_byte_lane, 3'b000} +: 8]  = data_i[7:0];
         c_MODE_HALF: w_new[{w_half_lane, 4'b0000} +: 16] = data_i[15:0];
         default:     w_new = data_i;
      endcase
   end

   // Combinational read with zero extension for narrow accesses.
   always_comb begin
      w_rd_byte = w_cur[{w_byte_lane, 3'b000} +: 8];
      w_rd_half = w_cur[{w_half_lane, 4'b0000} +: 16];
      case (w_mode)
         c_MODE_BYTE: data_o = {24'h00_0000, w_rd_byte};
         c_MODE_HALF: data_o = {16'h0000, w_rd_half};
         default:     data_o = w_cur;
      endcase
   end

   // Valid bits: cleared immediately by reset, set by any write. While reset
   // is held no word can become valid, so writes are effectively blocked.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_valid <= '0;
      end else if (wren_i) begin
         r_valid[w_idx] <= 1'b1;
      end
   end

   // Data storage: store the merged word on every write.
   always_ff @(posedge CLK) begin
      if (wren_i) begin
         r_mem[w_idx] <= w_new;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_manager_generic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_manager_generic
//  Description : Scoreboard bench for data_memory_manager_generic. Stimulus
//                pushes expected read data into a queue; a monitor pops and
//                compares on every cycle flagged as a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_manager_generic;

   localparam int ADDR_W = 16;

   logic        clk;
   logic        rst_n;
   logic [31:0] address_i;
   logic [31:0] data_i;
   logic        wren_i;
   logic [31:0] byte_mode_i;
   logic [31:0] data_o;

   logic        rd_valid;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model [int unsigned];

   int n_cmp;
   int n_err;
   bit stim_done;

   data_memory_manager_generic #(.ADDR_W(ADDR_W)) u_dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .address_i  (address_i),
      .data_i     (data_i),
      .wren_i     (wren_i),
      .byte_mode_i(byte_mode_i),
      .data_o     (data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int unsigned word_key(input logic [31:0] addr);
      return (addr >> 2) % (32'd1 << ADDR_W);
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      int unsigned k = word_key(addr);
      if (model.exists(k)) return model[k];
      return 32'h0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [31:0] mode);
      logic [31:0] w = model_word(addr);
      case (mode % 4)
         1:       return (w >> (8 * (addr % 4))) & 32'hFF;
         2:       return (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [31:0] mode);
      logic [31:0] w = model_word(addr);
      logic [31:0] mask;
      int sh;
      case (mode % 4)
         1: begin
            sh   = 8 * int'(addr % 4);
            mask = 32'hFF << sh;
            w    = (w & ~mask) | ((data & 32'hFF) << sh);
         end
         2: begin
            sh   = 16 * int'((addr / 2) % 2);
            mask = 32'hFFFF << sh;
            w    = (w & ~mask) | ((data & 32'hFFFF) << sh);
         end
         default: w = data;
      endcase
      model[word_key(addr)] = w;
   endfunction

   function automatic void push_exp(input string name, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endfunction

   // ---------------- stimulus tasks ----------------
   // One access per cycle; the check happens on the following falling edge,
   // before the write (if any) lands, so it observes pre-write contents.
   task automatic do_write(input string name, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] mode);
      @(posedge clk); #1;
      address_i   = addr;
      data_i      = data;
      byte_mode_i = mode;
      wren_i      = 1'b1;
      rd_valid    = 1'b1;
      push_exp(name, model_read(addr, mode));
      model_write(addr, data, mode);
   endtask

   task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] mode);
      @(posedge clk); #1;
      address_i   = addr;
      data_i      = $urandom;
      byte_mode_i = mode;
      wren_i      = 1'b0;
      rd_valid    = 1'b1;
      push_exp(name, model_read(addr, mode));
   endtask

   // Assert reset between clock edges while a write is being presented.
   task automatic do_reset(input logic [31:0] addr);
      @(posedge clk); #3;
      address_i   = addr;
      data_i      = $urandom;
      byte_mode_i = 32'h0;
      wren_i      = 1'b1;
      rst_n       = 1'b0;
      model.delete();
      rd_valid    = 1'b1;
      push_exp("rst_immediate", 32'h0);
      @(posedge clk); #1;
      push_exp("rst_hold_write_blocked", 32'h0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      wren_i   = 1'b0;
      rd_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r = $urandom;
      // Keep hits within 16 words but randomise the wrapped upper bits.
      return {r[31:ADDR_W+2], {(ADDR_W-4){1'b0}}, r[5:0]};
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rd_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_underflow: data_o=%08h with no expected entry", data_o);
            end else begin
               e = sb_q.pop_front();
               if (data_o !== e.exp) begin
                  n_err++;
                  $display("FAIL %s: addr=%08h mode=%08h got %08h expected %08h",
                           e.name, address_i, byte_mode_i, data_o, e.exp);
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a, d, m;
      logic [31:0] filled [4];
      n_cmp = 0; n_err = 0; stim_done = 0;
      rst_n = 1'b0; address_i = 0; data_i = 0; wren_i = 0; byte_mode_i = 0; rd_valid = 0;

      do_read("reset_state_a0", 32'h0, 32'h0);
      do_read("reset_state_a44", 32'h44, 32'h1);
      @(posedge clk); #1; rst_n = 1'b1; rd_valid = 1'b0;

      // word write/read with forced alignment
      do_write("word_wr_pre", 32'h1, 32'h0F0F_0F0F, 32'h0);
      do_read ("word_rd_a1", 32'h1, 32'h0);
      do_read ("word_rd_a0", 32'h0, 32'h3);

      // byte merge
      do_write("bm_word_wr", 32'h8, 32'h1122_3344, 32'h0);
      do_write("bm_byte_wr", 32'hA, 32'hFFFF_FFAA, 32'h1);
      do_read ("bm_word_rd", 32'h8, 32'h0);
      do_read ("bm_byte_rd", 32'hA, 32'hFFFF_FFFD);

      // halfword
      do_write("hw_word_wr", 32'h10, 32'h1234_5678, 32'h0);
      do_write("hw_half_wr", 32'h12, 32'h9999_BEEF, 32'h2);
      do_read ("hw_word_rd", 32'h10, 32'h0);
      do_read ("hw_half_rd", 32'h12, 32'h2);
      do_read ("hw_half_lo", 32'h10, 32'h6);

      // wrap modulo memory size
      do_write("wrap_wr", 32'h1 << (ADDR_W + 2), 32'hCAFE_F00D, 32'h0);
      do_read ("wrap_rd", 32'h0, 32'h0);

      // wren_i low for several clocks leaves contents unchanged
      for (int i = 0; i < 4; i++) do_read("no_wren_hold", 32'h8, 32'h0);

      // back-to-back writes to one word merge lanes
      do_write("b2b_0", 32'h20, 32'hA5A5_A5A5, 32'h0);
      do_write("b2b_1", 32'h21, 32'h0000_0011, 32'h1);
      do_write("b2b_2", 32'h22, 32'h0000_2233, 32'h2);
      do_read ("b2b_rd", 32'h20, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         a = rand_addr();
         d = $urandom;
         m = $urandom;
         if ($urandom_range(0, 1) == 1) do_write("rand_wr", a, d, m);
         else                           do_read ("rand_rd", a, m);
      end

      // fill, reset mid-write, confirm everything reads zero afterwards
      for (int i = 0; i < 4; i++) begin
         filled[i] = 32'h100 + 32'(i * 4);
         do_write("fill", filled[i], $urandom | 32'h1, 32'h0);
      end
      do_reset(filled[0]);
      for (int i = 0; i < 4; i++) do_read("post_reset_zero", filled[i], 32'h0);
      do_read("post_reset_zero_a8", 32'h8, 32'h0);

      // writes resume after reset release
      do_write("resume_wr", 32'h104, 32'h5566_7788, 32'h0);
      do_read ("resume_rd", 32'h104, 32'h0);
      do_read ("resume_byte", 32'h107, 32'h1);

      @(posedge clk); #1; rd_valid = 1'b0; wren_i = 1'b0;
      repeat (3) @(posedge clk);
      stim_done = 1;
   end

   initial begin
      fork
         wait (stim_done);
         #200000;
      join_any
      #1;
      if (!stim_done) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: stimulus did not complete, expected completion");
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
